ce_window_gen: RTL and testbench

//  Streaming sliding-window generator that feeds a CE. Accepts one pixel per cycle in row-major

---
 rtl/ce_window_gen_pkg.sv | 35 +++
 rtl/ce_window_gen_if.sv | 31 +++
 rtl/ce_line_buf.sv | 33 +++
 rtl/ce_window_gen.sv | 157 +++++++++++++++
 tb/tb_ce_window_gen.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/ce_window_gen_pkg.sv
// ce_window_gen_pkg
//   Shared constants and helpers for the sliding-window generator and the CE
//   that consumes its output. The packing index is the single definition of
//   the data2conv layout, so producer and consumer cannot drift apart.
//   Exports: MAX_KERNEL, cnt_w(), win_elems(), win_bits(), pack_idx(), last_pos().
package ce_window_gen_pkg;

    localparam int MAX_KERNEL = 7;

    // Counter width for a 0..size-1 counter; never narrower than one bit.
    function automatic int cnt_w(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    // Elements per channel in one window.
    function automatic int win_elems(input int kernel);
        return kernel * kernel;
    endfunction

    // Width of one flattened window.
    function automatic int win_bits(input int cl_in, input int kernel, input int n);
        return cl_in * win_elems(kernel) * n;
    endfunction

    // data2conv element index: channel-major, then row (top = oldest), then column.
    function automatic int pack_idx(input int c, input int r, input int k, input int kernel);
        return (c * kernel + r) * kernel + k;
    endfunction

    // Last row/column position that produces a window.
    function automatic int last_pos(input int size, input int kernel, input bit stride2);
        return stride2 ? (kernel - 1) + 2 * ((size - kernel) / 2) : size - 1;
    endfunction

endpackage

// File: rtl/ce_window_gen_if.sv
// ce_window_gen_if
//   Pixel-in / window-out bus of the window generator.
//   pix_in     CL_IN*N      pixel, channel c at pix_in[c*N +: N]
//   pix_valid  1            pixel present (no backpressure)
//   data2conv  win_bits     flattened window to the CE
//   en_out     1            data2conv valid pulse (drives CE en_in)
//   frame_done 1            pulse with the last window of a frame
//   Modports: master = pixel source / window sink, slave = generator.
interface ce_window_gen_if
    import ce_window_gen_pkg::*;
#(
    parameter int CL_IN  = 2,
    parameter int KERNEL = 7,
    parameter int N      = 4
);
    logic [CL_IN*N-1:0]                     pix_in;
    logic                                   pix_valid;
    logic [win_bits(CL_IN, KERNEL, N)-1:0]  data2conv;
    logic                                   en_out;
    logic                                   frame_done;

    modport master (
        output pix_in, pix_valid,
        input  data2conv, en_out, frame_done
    );

    modport slave (
        input  pix_in, pix_valid,
        output data2conv, en_out, frame_done
    );
endinterface

// File: rtl/ce_line_buf.sv
// ce_line_buf
//   One image line of storage: DEPTH x W simple dual-port RAM, synchronous
//   write, registered read. Not reset; contents are only ever consumed after
//   they have been rewritten in the current frame.
//   clk      clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_addr  read address (result appears the cycle after)
//   rd_data  registered read data
module ce_line_buf
    import ce_window_gen_pkg::*;
#(
    parameter int DEPTH = 28,
    parameter int W     = 8,
    parameter int AW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ce_window_gen.sv
// ce_window_gen
//   Streaming KERNEL x KERNEL sliding-window generator feeding a CE. Takes one
//   row-major pixel per accepted cycle, keeps KERNEL-1 previous lines in a
//   cascade of ce_line_buf RAMs and emits every unpadded window, flattened
//   with pack_idx(), one cycle after the pixel that completes it.
//   clk   clock, rising edge
//   rst   asynchronous reset, active low
//   bus   ce_window_gen_if.slave (pix_in/pix_valid in, data2conv/en_out/frame_done out)
//   Build option: CE_WIN_STRIDE2_EN selects stride 2 (only windows whose
//   offsets from the first valid row/column are both even are emitted).
module ce_window_gen
    import ce_window_gen_pkg::*;
#(
    parameter int CL_IN  = 2,
    parameter int KERNEL = 7,
    parameter int N      = 4,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic           clk,
    input  logic           rst,
    ce_window_gen_if.slave bus
);

`ifdef CE_WIN_STRIDE2_EN
    localparam bit STRIDE2 = 1'b1;
`else
    localparam bit STRIDE2 = 1'b0;
`endif

    localparam int CW       = cnt_w(IMG_W);
    localparam int RW       = cnt_w(IMG_H);
    localparam int PW       = CL_IN * N;
    localparam int NLB      = KERNEL - 1;
    localparam int LBN      = (NLB > 0) ? NLB : 1;
    localparam int WB       = win_bits(CL_IN, KERNEL, N);
    localparam int LAST_ROW = last_pos(IMG_H, KERNEL, STRIDE2);
    localparam int LAST_COL = last_pos(IMG_W, KERNEL, STRIDE2);

    logic                              accept;
    logic [CW-1:0]                     col, col_nxt;
    logic [RW-1:0]                     row, row_nxt;
    logic [PW-1:0]                     lb_q [LBN];
    logic [KERNEL-1:0][PW-1:0]         new_col;
    logic [KERNEL-1:0][KERNEL-1:0][PW-1:0] win, win_nxt;   // [row][col]
    logic [WB-1:0]                     win_flat;
    logic                              stride_ok;
    logic                              win_ok;
    logic                              is_last;

    assign accept = bus.pix_valid;

    // Raster position of the pixel being presented; wraps at end of frame.
    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (accept) begin
            if (col == CW'(IMG_W - 1)) begin
                col_nxt = '0;
                row_nxt = (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
            end else begin
                col_nxt = col + 1'b1;
            end
        end
    end

    // Line-buffer cascade: stage 0 stores the incoming line, stage j stores
    // the line j+1 rows above. The read address is the position of the
    // *next* pixel, so the registered read data is ready when it arrives,
    // also across gaps (col_nxt == col while idle).
    generate
        if (NLB > 0) begin : g_lb
            for (genvar j = 0; j < NLB; j++) begin : g_stage
                logic [PW-1:0] wr_data;
                if (j == 0) begin : g_head
                    assign wr_data = bus.pix_in;
                end else begin : g_tail
                    assign wr_data = lb_q[j-1];
                end
                ce_line_buf #(
                    .DEPTH (IMG_W),
                    .W     (PW),
                    .AW    (CW)
                ) u_lb (
                    .clk     (clk),
                    .wr_en   (accept),
                    .wr_addr (col),
                    .wr_data (wr_data),
                    .rd_addr (col_nxt),
                    .rd_data (lb_q[j])
                );
            end
        end else begin : g_no_lb
            assign lb_q[0] = '0;
        end
    endgenerate

    // Incoming column: oldest line on top, live pixel at the bottom.
    always_comb begin
        new_col = '0;
        new_col[KERNEL-1] = bus.pix_in;
        for (int j = 0; j < NLB; j++) new_col[KERNEL-2-j] = lb_q[j];
    end

    // Window after shifting one column left.
    always_comb begin
        win_nxt = win;
        for (int r = 0; r < KERNEL; r++) begin
            for (int k = 0; k < KERNEL - 1; k++) win_nxt[r][k] = win[r][k+1];
            win_nxt[r][KERNEL-1] = new_col[r];
        end
    end

    // Flatten the post-shift window so the output register captures the
    // window that includes the pixel accepted this cycle.
    always_comb begin
        win_flat = '0;
        for (int c = 0; c < CL_IN; c++)
            for (int r = 0; r < KERNEL; r++)
                for (int k = 0; k < KERNEL; k++)
                    win_flat[pack_idx(c, r, k, KERNEL)*N +: N] = win_nxt[r][k][c*N +: N];
    end

`ifdef CE_WIN_STRIDE2_EN
    logic [RW-1:0] row_off;
    logic [CW-1:0] col_off;
    assign row_off   = row - RW'(KERNEL - 1);
    assign col_off   = col - CW'(KERNEL - 1);
    assign stride_ok = ~row_off[0] & ~col_off[0];
`else
    assign stride_ok = 1'b1;
`endif

    // col gate stops windows straddling two rows (stale left columns); row
    // gate stops stale line data leaking into the first rows of a frame.
    assign win_ok  = (row >= RW'(KERNEL - 1)) && (col >= CW'(KERNEL - 1)) && stride_ok;
    assign is_last = (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col            <= '0;
            row            <= '0;
            win            <= '0;
            bus.en_out     <= 1'b0;
            bus.frame_done <= 1'b0;
            bus.data2conv  <= '0;
        end else begin
            col            <= col_nxt;
            row            <= row_nxt;
            if (accept) win <= win_nxt;
            bus.en_out     <= accept & win_ok;
            bus.frame_done <= accept & win_ok & is_last;
            if (accept && win_ok) bus.data2conv <= win_flat;
        end
    end

endmodule

// File: tb/tb_ce_window_gen.sv
module tb_ce_window_gen;

    localparam int K = 3;
    localparam int N = 4;
    localparam int W = 5;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ce_window_gen_if #(.CL_IN(1), .KERNEL(K), .N(N)) bus1 ();
    ce_window_gen_if #(.CL_IN(2), .KERNEL(K), .N(N)) bus2 ();

    ce_window_gen #(.CL_IN(1), .KERNEL(K), .N(N), .IMG_W(W), .IMG_H(H)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1));
    ce_window_gen #(.CL_IN(2), .KERNEL(K), .N(N), .IMG_W(W), .IMG_H(H)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2));

    int errors = 0;
    int checks = 0;
    int tb_row = 0;
    int tb_col = 0;
    int n_en [2];
    int n_fd [2];
    logic [127:0] last_d [2];
    logic [127:0] q1 [$];
    logic [127:0] q2 [$];
    bit qf1 [$];
    bit qf2 [$];

    task automatic check(input int id, input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL dut%0d %s: got %0h want %0h", id, tag, act, exp);
        end
    endtask

    function automatic logic [3:0] pv(input int r, input int c, input int seed);
        return 4'((r * W + c + seed) % 16);
    endfunction

    function automatic bit emits(input int r, input int c);
        bit e;
        e = (r >= K - 1) && (c >= K - 1);
`ifdef CE_WIN_STRIDE2_EN
        e = e && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
        return e;
    endfunction

    // Last window of the frame: emitting position with no emitting position after it.
    function automatic bit is_last(input int r, input int c);
        bit l;
        l = emits(r, c);
        for (int p = r * W + c + 1; p < W * H; p++)
            if (emits(p / W, p % W)) l = 1'b0;
        return l;
    endfunction

    function automatic logic [127:0] exp_win(input int r0, input int c0, input int seed, input int ncl);
        logic [127:0] w;
        w = '0;
        for (int c = 0; c < ncl; c++)
            for (int r = 0; r < K; r++)
                for (int k = 0; k < K; k++)
                    w[((c * K + r) * K + k) * N +: N] =
                        pv(r0 - (K - 1) + r, c0 - (K - 1) + k, seed) + 4'(8 * c);
        return w;
    endfunction

    task automatic send(input int seed);
        logic [3:0] p;
        @(posedge clk); #1;
        p = pv(tb_row, tb_col, seed);
        bus1.pix_valid = 1'b1;
        bus1.pix_in    = p;
        bus2.pix_valid = 1'b1;
        bus2.pix_in    = {p + 4'd8, p};
        if (emits(tb_row, tb_col)) begin
            q1.push_back(exp_win(tb_row, tb_col, seed, 1));
            qf1.push_back(is_last(tb_row, tb_col));
            q2.push_back(exp_win(tb_row, tb_col, seed, 2));
            qf2.push_back(is_last(tb_row, tb_col));
        end
        if (tb_col == W - 1) begin
            tb_col = 0;
            tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
        end else begin
            tb_col++;
        end
    endtask

    // Idle cycles carry junk on pix_in to prove it is ignored without pix_valid.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus1.pix_valid = 1'b0;
            bus2.pix_valid = 1'b0;
            bus1.pix_in    = 4'($urandom);
            bus2.pix_in    = 8'($urandom);
        end
    endtask

    task automatic frame(input int seed);
        for (int i = 0; i < W * H; i++) send(seed);
    endtask

    task automatic monitor(input int id, input logic en, input logic fd, input logic [127:0] d);
        logic [127:0] e;
        bit ef;
        bit got;
        got = 1'b0;
        e   = '0;
        ef  = 1'b0;
        if (!rst) begin
            check(id, "rst_en_out", 128'(en), 128'd0);
            check(id, "rst_frame_done", 128'(fd), 128'd0);
            check(id, "rst_data2conv", d, 128'd0);
            last_d[id] = '0;
        end else if (en) begin
            n_en[id]++;
            if (fd) n_fd[id]++;
            if (id == 0 && q1.size() > 0) begin
                e = q1.pop_front(); ef = qf1.pop_front(); got = 1'b1;
            end else if (id == 1 && q2.size() > 0) begin
                e = q2.pop_front(); ef = qf2.pop_front(); got = 1'b1;
            end
            check(id, "window_expected", 128'(got), 128'd1);
            if (got) begin
                check(id, "data2conv", d, e);
                check(id, "frame_done", 128'(fd), 128'(ef));
                last_d[id] = e;
            end
        end else begin
            check(id, "data_hold", d, last_d[id]);
            check(id, "frame_done_idle", 128'(fd), 128'd0);
        end
    endtask

    task automatic expect_count(input string tag, input int s0, input int s1, input int f0, input int f1,
                                input int n_win, input int n_frames);
        check(0, {tag, "_windows"}, 128'(n_en[0] - s0), 128'(n_win));
        check(1, {tag, "_windows"}, 128'(n_en[1] - s1), 128'(n_win));
        check(0, {tag, "_frame_done"}, 128'(n_fd[0] - f0), 128'(n_frames));
        check(1, {tag, "_frame_done"}, 128'(n_fd[1] - f1), 128'(n_frames));
        check(0, {tag, "_drained"}, 128'(q1.size()), 128'd0);
        check(1, {tag, "_drained"}, 128'(q2.size()), 128'd0);
    endtask

    initial begin
        int wpf, s0, s1, f0, f1;
        n_en = '{0, 0};
        n_fd = '{0, 0};
        last_d = '{128'd0, 128'd0};
        bus1.pix_valid = 1'b0;
        bus1.pix_in    = '0;
        bus2.pix_valid = 1'b0;
        bus2.pix_in    = '0;
        wpf = 0;
        for (int p = 0; p < W * H; p++) if (emits(p / W, p % W)) wpf++;

        fork
            forever begin
                @(negedge clk);
                monitor(0, bus1.en_out, bus1.frame_done, 128'(bus1.data2conv));
                monitor(1, bus2.en_out, bus2.frame_done, 128'(bus2.data2conv));
            end
        join_none

        // Reset state.
        #2 rst = 1'b0;
        idle(3);
        @(posedge clk); #1 rst = 1'b1;
        idle(2);

        // 1: one frame, continuous.
        s0 = n_en[0]; s1 = n_en[1]; f0 = n_fd[0]; f1 = n_fd[1];
        frame(0);
        idle(3);
        expect_count("t1", s0, s1, f0, f1, wpf, 1);

        // 2: pix_valid toggling every cycle.
        s0 = n_en[0]; s1 = n_en[1]; f0 = n_fd[0]; f1 = n_fd[1];
        for (int i = 0; i < W * H; i++) begin
            send(0);
            idle(1);
        end
        idle(2);
        expect_count("t2", s0, s1, f0, f1, wpf, 1);

        // 3: two frames back to back, different content in the second.
        s0 = n_en[0]; s1 = n_en[1]; f0 = n_fd[0]; f1 = n_fd[1];
        frame(0);
        frame(5);
        idle(3);
        expect_count("t3", s0, s1, f0, f1, 2 * wpf, 2);

        // 4: reset after pixel 13 aborts the frame; next frame starts at (0,0).
        for (int i = 0; i < 14; i++) send(0);
        idle(2);
        @(posedge clk); #1;
        rst = 1'b0;
        tb_row = 0;
        tb_col = 0;
        idle(3);
        @(posedge clk); #1 rst = 1'b1;
        s0 = n_en[0]; s1 = n_en[1]; f0 = n_fd[0]; f1 = n_fd[1];
        frame(9);
        idle(3);
        expect_count("t4", s0, s1, f0, f1, wpf, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
